// File: rtl/alu_pkg.sv
// Shared ALU package: op encodings, XLEN, and multiplier controller states.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b1010;
  localparam logic [3:0] ALU_SRL  = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Operand/result handshakes plus ALU drive for the sequential multiplier.
interface alu_mul_seq_if;
  import alu_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_prod;
  logic            alu_grant_o;
  logic [XLEN-1:0] alu_in_1;
  logic [XLEN-1:0] alu_in_2;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] alu_result;

  modport master (
    output in_valid, in_a, in_b, flush, out_ready, alu_result,
    input  in_ready, out_valid, out_prod,
    input  alu_grant_o, alu_in_1, alu_in_2, alu_op
  );

  modport slave (
    input  in_valid, in_a, in_b, flush, out_ready, alu_result,
    output in_ready, out_valid, out_prod,
    output alu_grant_o, alu_in_1, alu_in_2, alu_op
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier that borrows the shared ALU one add per cycle.
// Define MUL_EARLY_TERM_EN to stop once the remaining multiplier is zero.
module alu_mul_seq
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  alu_mul_seq_if.slave bus
);

  mul_state_t      state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] prod_q, prod_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            last_step;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    acc_d           = acc_q;
    mcand_d         = mcand_q;
    mplier_d        = mplier_q;
    prod_d          = prod_q;
    cnt_d           = cnt_q;
    last_step       = 1'b0;
    bus.in_ready    = 1'b0;
    bus.out_valid   = 1'b0;
    bus.alu_grant_o = 1'b0;
    bus.alu_in_1    = '0;
    bus.alu_in_2    = '0;

    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          acc_d    = '0;
          mcand_d  = bus.in_a;
          mplier_d = bus.in_b;
          cnt_d    = '0;
          state_d  = RUN;
`ifdef MUL_EARLY_TERM_EN
          if (bus.in_b == '0) begin
            state_d = DONE;
            prod_d  = '0;
          end
`endif
        end
      end
      RUN: begin
        bus.alu_grant_o = 1'b1;
        bus.alu_in_1    = acc_q;
        bus.alu_in_2    = mplier_q[0] ? mcand_q : '0;
        acc_d           = bus.alu_result;
        mcand_d         = {mcand_q[XLEN-2:0], 1'b0};
        mplier_d        = {1'b0, mplier_q[XLEN-1:1]};
        cnt_d           = cnt_q + 5'd1;
`ifdef MUL_EARLY_TERM_EN
        last_step       = (mplier_d == '0);
`else
        last_step       = (cnt_q == 5'd31);
`endif
        if (last_step) begin
          state_d = DONE;
          prod_d  = bus.alu_result;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything; the held product must not move.
    if (bus.flush) begin
      state_d = IDLE;
      prod_d  = prod_q;
    end
  end

  assign bus.out_prod = prod_q;
  assign bus.alu_op   = ALU_ADD;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Randomised self-checking bench for alu_mul_seq against a cycle-level model.
module tb_alu_mul_seq;

`ifdef MUL_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam int MI = 0;
  localparam int MR = 1;
  localparam int MD = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_mul_seq_if bus();

  alu_mul_seq dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  assign bus.alu_result = bus.alu_in_1 + bus.alu_in_2;

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] b);
    int bl;
    bl = 0;
    for (int i = 0; i < 32; i++) if (b[i]) bl = i + 1;
    if (!EARLY) return 33;
    if (b == 0) return 1;
    return bl + 1;
  endfunction

  // Behavioural model: phase, step count, operands, visible product
  int          mst;
  int          mk;
  logic [31:0] ma, mb, mprod;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mst   <= MI;
      mk    <= 0;
      ma    <= '0;
      mb    <= '0;
      mprod <= '0;
    end else if (bus.flush) begin
      mst <= MI;
    end else begin
      case (mst)
        MI: if (bus.in_valid) begin
          ma <= bus.in_a;
          mb <= bus.in_b;
          mk <= 0;
          if (EARLY && bus.in_b == 0) begin
            mst   <= MD;
            mprod <= '0;
          end else begin
            mst <= MR;
          end
        end
        MR: begin
          mk <= mk + 1;
          if (EARLY ? ((mb >> (mk + 1)) == 0) : (mk + 1 == 32)) begin
            mst   <= MD;
            mprod <= ma * mb;
          end
        end
        MD: if (bus.out_ready) mst <= MI;
        default: mst <= MI;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [63:0] m;
    logic [31:0] e1, e2;
    if (!reset) begin
      e1 = '0;
      e2 = '0;
      if (mst == MR) begin
        m  = (64'd1 << mk) - 64'd1;
        e1 = ma * (mb & m[31:0]);
        e2 = mb[mk] ? (ma << mk) : 32'd0;
      end
      chk("in_ready", 32'(bus.in_ready), 32'(mst == MI));
      chk("out_valid", 32'(bus.out_valid), 32'(mst == MD));
      chk("alu_grant", 32'(bus.alu_grant_o), 32'(mst == MR));
      chk("alu_op", 32'(bus.alu_op), 32'd0);
      chk("out_prod", bus.out_prod, mprod);
      chk("alu_in_1", bus.alu_in_1, e1);
      chk("alu_in_2", bus.alu_in_2, e2);
    end
  end

  // Called one time unit after a rising edge.
  task automatic accept(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_timeout", 32'(n < 100), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Called one time unit after the accept edge.
  task automatic await_result(input int hold, output logic [31:0] prod,
                              output int lat, output int g);
    lat = 1;
    g   = 0;
    bus.out_ready = (hold == 0);
    while (!bus.out_valid && lat < 100) begin
      if (bus.alu_grant_o) g++;
      @(posedge clk); #1;
      lat++;
    end
    chk("result_timeout", 32'(lat < 100), 32'd1);
    prod = bus.out_prod;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = $urandom;
      bus.in_b     = $urandom;
      @(posedge clk); #1;
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_prod", bus.out_prod, prod);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [31:0] a,
                        input logic [31:0] b, input int hold,
                        input logic [31:0] exp);
    logic [31:0] p;
    int lat, g;
    accept(a, b);
    await_result(hold, p, lat, g);
    chk({name, "_prod"}, p, exp);
    chk({name, "_lat"}, lat, exp_lat(b));
  endtask

  initial begin
    logic [31:0] p, a, b;
    int lat, g;

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_prod", bus.out_prod, 32'd0);
    chk("rst_grant", 32'(bus.alu_grant_o), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    accept(32'd3, 32'd5);
    await_result(0, p, lat, g);
    chk("3x5_prod", p, 32'd15);
    chk("3x5_lat", lat, EARLY ? 32'd4 : 32'd33);
    chk("3x5_grant", g, EARLY ? 32'd3 : 32'd32);

    run_op("ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h0000_0001);
    run_op("wrap", 32'h8000_0000, 32'd2, 0, 32'h0000_0000);

    accept(32'h0000_1234, 32'd0);
    await_result(0, p, lat, g);
    chk("b0_prod", p, 32'd0);
    chk("b0_lat", lat, EARLY ? 32'd1 : 32'd33);
    chk("b0_grant", g, EARLY ? 32'd0 : 32'd32);

    run_op("bp", 32'd9, 32'd11, 10, 32'd99);

    accept(32'hDEAD_BEEF, 32'h0000_FFFF);
    repeat (9) begin
      @(posedge clk); #1;
    end
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_a     = 32'd7;
    bus.in_b     = 32'd6;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_idle", 32'(bus.in_ready), 32'd1);
    chk("flush_nov", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("flush_acc", 32'(bus.in_ready), 32'd0);
    await_result(0, p, lat, g);
    chk("7x6_prod", p, 32'd42);

    accept(32'h0F0F_0F0F, 32'hF000_0001);
    repeat (5) begin
      @(posedge clk); #1;
    end
    #2 reset = 1'b1;
    #1;
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_grant", 32'(bus.alu_grant_o), 32'd0);
    chk("arst_prod", bus.out_prod, 32'd0);
    chk("arst_in1", bus.alu_in_1, 32'd0);
    chk("arst_in2", bus.alu_in_2, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_op("12345x678", 32'd12345, 32'd678, 0, 32'd8369910);

    for (int i = 0; i < 25; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (i % 8 == 3) b = 32'd0;
      run_op("rand", a, b, $urandom_range(0, 3), a * b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Iterative shift-and-add multiplier controller. It produces the low 32 bits of A×B by driving the shared 32-bit ALU one addition per cycle. It sits beside the ALU in the execute stage and owns the ALU ports only while busy; the parent muxes its ALU drive onto the ALU when `alu_grant_o` is high. Operand and result transfer uses valid/ready handshakes.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  controller idle and able to accept
- in_a  in  32  multiplicand
- in_b  in  32  multiplier
- flush  in  1  synchronous abort; returns to IDLE and drops the result
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_prod  out  32  low 32 bits of in_a×in_b
- alu_grant_o  out  1  high while in RUN; parent routes ALU from this block
- alu_in_1  out  32  accumulator
- alu_in_2  out  32  partial product (shifted multiplicand or 0)
- alu_op  out  4  fixed 4'b0000 (ADD)
- alu_result  in  32  ALU sum, combinational, same cycle

## Operation
- States: IDLE, RUN, DONE.
- IDLE
  - in_ready=1.
  - On in_valid: acc←0, mcand←in_a, mplier←in_b, cnt←0, go to RUN.
- RUN, one step per cycle:
  - Drive alu_in_1=acc, alu_in_2 = mplier[0] ? mcand : 0.
  - Update acc←alu_result; mcand←mcand<<1 (bit 31 discarded); mplier←mplier>>1 (logical); cnt←cnt+1.
  - After the step with cnt==31, go to DONE.
- DONE
  - out_valid=1 and out_prod=acc, held stable until out_ready.
  - On out_valid&&out_ready, go to IDLE.
- Arithmetic is modulo 2^32. The result is identical for signed and unsigned operands, so no sign handling is needed. Carry-out is ignored.
- flush
  - Any state → IDLE next cycle; out_valid deasserts.
  - flush has priority over in_valid and out_ready in the same cycle.
- ALU drive outside RUN: alu_in_1=alu_in_2=0, alu_op=4'b0000, alu_grant_o=0.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_prod=0, alu_grant_o=0, acc/mcand/mplier/cnt=0.
- Reset mid-operation: immediate return to the reset values; the in-flight result is lost.

## Timing
- Accept edge t (in_valid&&in_ready).
- RUN during cycles t+1..t+32.
- out_valid high from cycle t+33 (32-step latency plus DONE entry).
- A new request cannot be accepted in the same cycle as the result handshake. Next accept is no earlier than one cycle after the DONE→IDLE edge. Throughput is one operation per 34 cycles minimum.
- in_ready is combinational from state only, with no path from in_valid.
- out_prod changes only on entry to DONE.

## Configuration
- `MUL_EARLY_TERM_EN` defined:
  - RUN exits to DONE after any step where the updated mplier==0.
  - If in_b==0 at accept, go straight IDLE→DONE with acc=0; out_valid appears at t+1.
  - Latency = t+1+(index of in_b's MSB +1).
- Undefined: always exactly 32 RUN steps, independent of operands.

## Structure
- Shared package `alu_pkg`:
  - ALU op constants (ALU_ADD=4'b0000, ALU_SUB=4'b0001, ALU_SLL=4'b1010, ALU_SRL=4'b1011, etc.).
  - `mul_state_t` enum {IDLE, RUN, DONE}.
  - XLEN.
- No sub-module. The ALU is instantiated in the parent, and the mux onto it lives there, keyed by alu_grant_o.

## Test plan
- a=3, b=5, out_ready=1: out_prod=15. out_valid rises exactly 33 cycles after accept without the macro, 4 cycles with it. alu_grant_o is high for 32 / 3 cycles respectively.
- a=0xFFFFFFFF, b=0xFFFFFFFF: out_prod=0x00000001. a=0x80000000, b=2: out_prod=0 (wrap).
- b=0 with `MUL_EARLY_TERM_EN`: out_valid at t+1, out_prod=0, alu_grant_o never asserted. Without the macro: out_prod=0 at t+33.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. out_prod and out_valid stay stable and in_ready stays 0. A new in_valid during this window is not accepted.
- flush asserted at RUN step 10 together with in_valid: next cycle IDLE, out_valid never rises, and in_valid is accepted one cycle later. Subsequent a=7, b=6 gives 42.
- reset asserted asynchronously mid-RUN: all outputs go to reset values without waiting for a clock edge. After release, a=12345, b=678 gives 8369910.
